// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game datapath.
// Used by the button front-end, the game FSM and the LED driver.
package simon_pkg;

  localparam int NUM_BTN   = 4;
  localparam int BTN_IDX_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } btn_state_t;

  // Maps a one-hot button vector to its index; non-one-hot inputs give 0.
  function automatic logic [BTN_IDX_W-1:0] onehot_to_idx(input logic [NUM_BTN-1:0] onehot);
    logic [BTN_IDX_W-1:0] idx;
    case (onehot)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // True when two or more bits of the vector are set.
  function automatic logic is_multi(input logic [NUM_BTN-1:0] vec);
    return (vec & (vec - {{(NUM_BTN-1){1'b0}}, 1'b1})) != {NUM_BTN{1'b0}};
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Two-flop synchroniser plus stable-count debouncer for one raw button bit.
// The debounced level only changes after DEBOUNCE_CYCLES consecutive mismatched cycles.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic deb
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             deb_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchroniser chain and mismatch counter; the counter restarts on any agreeing cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      deb_r   <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      if (sync2_r == deb_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        deb_r <= ~deb_r;
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign deb = deb_r;

endmodule

// File: rtl/btn_input.sv
// Simon button front-end: debounces four buttons and emits one press event per
// physical press, or a multi_err pulse when several buttons debounce together.
module btn_input
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_BTN-1:0]   btn,
  input  logic                 accept_en,
  output logic                 press_valid,
  output logic [BTN_IDX_W-1:0] press_val,
  output logic                 multi_err,
  output logic [NUM_BTN-1:0]   btn_level
);

  logic [NUM_BTN-1:0]   deb_s;
  btn_state_t           state_r;
  btn_state_t           state_nxt_s;
  logic                 press_valid_r;
  logic                 press_valid_nxt_s;
  logic [BTN_IDX_W-1:0] press_val_r;
  logic [BTN_IDX_W-1:0] press_val_nxt_s;
  logic                 multi_err_r;
  logic                 multi_err_nxt_s;
  logic [NUM_BTN-1:0]   btn_level_r;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce_bit (
      .clk  (clk),
      .reset(reset),
      .btn  (btn[i]),
      .deb  (deb_s[i])
    );
  end

  // Press FSM: only the first debounced activity after an all-released state counts.
  always_comb begin
    state_nxt_s       = state_r;
    press_valid_nxt_s = 1'b0;
    press_val_nxt_s   = press_val_r;
    multi_err_nxt_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (deb_s == {NUM_BTN{1'b0}}) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HELD;
          if (is_multi(deb_s)) begin
            multi_err_nxt_s = 1'b1;
          end else if (accept_en) begin
            press_valid_nxt_s = 1'b1;
            press_val_nxt_s   = onehot_to_idx(deb_s);
          end else begin
            press_valid_nxt_s = 1'b0;
          end
        end
      end
      HELD: begin
        if (deb_s == {NUM_BTN{1'b0}}) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HELD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State and registered outputs; btn_level shares the output stage so it lines up with events.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      press_valid_r <= 1'b0;
      press_val_r   <= {BTN_IDX_W{1'b0}};
      multi_err_r   <= 1'b0;
      btn_level_r   <= {NUM_BTN{1'b0}};
    end else begin
      state_r       <= state_nxt_s;
      press_valid_r <= press_valid_nxt_s;
      press_val_r   <= press_val_nxt_s;
      multi_err_r   <= multi_err_nxt_s;
      btn_level_r   <= deb_s;
    end
  end

  assign press_valid = press_valid_r;
  assign press_val   = press_val_r;
  assign multi_err   = multi_err_r;
  assign btn_level   = btn_level_r;

endmodule

// File: tb/tb_btn_input.sv
// Self-checking bench for btn_input: directed scenarios plus random stimulus,
// compared cycle by cycle against a window-based behavioural model.
module tb_btn_input;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic       accept_en;
  logic       press_valid;
  logic [1:0] press_val;
  logic       multi_err;
  logic [3:0] btn_level;

  int errors = 0;
  int checks = 0;

  btn_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn        (btn),
    .accept_en  (accept_en),
    .press_valid(press_valid),
    .press_val  (press_val),
    .multi_err  (multi_err),
    .btn_level  (btn_level)
  );

  always #5 clk = ~clk;

  // Reference model: a debounced bit flips once the raw samples taken two to
  // D+1 edges ago all disagree with it; events fire on the first non-zero
  // debounced vector after everything was released.
  logic [3:0] hist [0:D];
  logic [3:0] m_deb, m_level, flip_s;
  logic       m_armed, m_valid, m_multi;
  logic [1:0] m_val;

  function automatic logic [1:0] idx_of(input logic [3:0] v);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  always_comb begin
    flip_s = 4'b1111;
    for (int b = 0; b < 4; b++)
      for (int j = 1; j <= D; j++)
        if (hist[j][b] == m_deb[b]) flip_s[b] = 1'b0;
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j <= D; j++) hist[j] <= 4'b0000;
      m_deb <= 4'b0000; m_level <= 4'b0000; m_armed <= 1'b1;
      m_valid <= 1'b0; m_multi <= 1'b0; m_val <= 2'd0;
    end else begin
      hist[0] <= btn;
      for (int j = 1; j <= D; j++) hist[j] <= hist[j-1];
      m_deb   <= m_deb ^ flip_s;
      m_level <= m_deb;
      m_valid <= 1'b0;
      m_multi <= 1'b0;
      if (m_deb == 4'b0000) begin
        m_armed <= 1'b1;
      end else if (m_armed) begin
        m_armed <= 1'b0;
        if ($countones(m_deb) > 1) m_multi <= 1'b1;
        else if (accept_en) begin
          m_valid <= 1'b1;
          m_val   <= idx_of(m_deb);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn = 4'b0000; accept_en = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    checks++;
    if ({press_valid, press_val, multi_err, btn_level} !== 8'h00) begin
      errors++; $display("FAIL reset_state: got %b want 00000000", {press_valid, press_val, multi_err, btn_level});
    end
  endtask

  task automatic test_clean_press();
    int n = 0, at = -1; logic [1:0] v = 2'd0; logic [3:0] lvl = 4'b0000;
    btn = 4'b0100;
    for (int i = 0; i < 35; i++) begin
      if (i == 20) btn = 4'b0000;
      tick();
      checks++;
      if ({press_valid, press_val, multi_err, btn_level} !== {m_valid, m_val, m_multi, m_level}) begin
        errors++; $display("FAIL clean_model c%0d: got %b want %b", i, {press_valid, press_val, multi_err, btn_level}, {m_valid, m_val, m_multi, m_level});
      end
      if (press_valid) begin n++; at = i; v = press_val; end
      if (i == 12) lvl = btn_level;
    end
    checks++; if (n != 1)       begin errors++; $display("FAIL clean_count: got %0d want 1", n); end
    checks++; if (at != 6)      begin errors++; $display("FAIL clean_latency: got %0d want 6", at); end
    checks++; if (v !== 2'd2)   begin errors++; $display("FAIL clean_val: got %0d want 2", v); end
    checks++; if (lvl !== 4'b0100) begin errors++; $display("FAIL clean_level: got %b want 0100", lvl); end
    checks++; if (btn_level !== 4'b0000) begin errors++; $display("FAIL clean_release: got %b want 0000", btn_level); end
  endtask

  task automatic test_bounce();
    int n = 0, at = -1; logic [1:0] v = 2'd3;
    for (int i = 0; i < 47; i++) begin
      if (i < 12) btn = ((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
      else if (i < 32) btn = 4'b0001;
      else btn = 4'b0000;
      tick();
      checks++;
      if ({press_valid, press_val, multi_err, btn_level} !== {m_valid, m_val, m_multi, m_level}) begin
        errors++; $display("FAIL bounce_model c%0d: got %b want %b", i, {press_valid, press_val, multi_err, btn_level}, {m_valid, m_val, m_multi, m_level});
      end
      if (press_valid) begin n++; at = i; v = press_val; end
    end
    checks++; if (n != 1)     begin errors++; $display("FAIL bounce_count: got %0d want 1", n); end
    checks++; if (at != 18)   begin errors++; $display("FAIL bounce_latency: got %0d want 18", at); end
    checks++; if (v !== 2'd0) begin errors++; $display("FAIL bounce_val: got %0d want 0", v); end
  endtask

  task automatic test_simultaneous();
    int np = 0, nm = 0; logic [1:0] v = 2'd0;
    for (int i = 0; i < 60; i++) begin
      btn = (i < 15) ? 4'b0011 : (i >= 30 && i < 45) ? 4'b1000 : 4'b0000;
      tick();
      checks++;
      if ({press_valid, press_val, multi_err, btn_level} !== {m_valid, m_val, m_multi, m_level}) begin
        errors++; $display("FAIL simul_model c%0d: got %b want %b", i, {press_valid, press_val, multi_err, btn_level}, {m_valid, m_val, m_multi, m_level});
      end
      if (multi_err) nm++;
      if (press_valid) begin np++; v = press_val; if (i < 30) begin errors++; $display("FAIL simul_no_press: got press_valid=1 want 0 at c%0d", i); end end
    end
    checks++; if (nm != 1)    begin errors++; $display("FAIL simul_multi: got %0d want 1", nm); end
    checks++; if (np != 1)    begin errors++; $display("FAIL simul_next_count: got %0d want 1", np); end
    checks++; if (v !== 2'd3) begin errors++; $display("FAIL simul_next_val: got %0d want 3", v); end
  endtask

  task automatic test_overlap();
    int np = 0, nm = 0; logic [1:0] v1 = 2'd0, v2 = 2'd0;
    for (int i = 0; i < 70; i++) begin
      btn = (i < 10) ? 4'b0010 : (i < 20) ? 4'b1010 : (i >= 35 && i < 50) ? 4'b1000 : 4'b0000;
      tick();
      checks++;
      if ({press_valid, press_val, multi_err, btn_level} !== {m_valid, m_val, m_multi, m_level}) begin
        errors++; $display("FAIL overlap_model c%0d: got %b want %b", i, {press_valid, press_val, multi_err, btn_level}, {m_valid, m_val, m_multi, m_level});
      end
      if (multi_err) nm++;
      if (press_valid) begin np++; if (i < 35) v1 = press_val; else v2 = press_val; end
    end
    checks++; if (np != 2 || nm != 0) begin errors++; $display("FAIL overlap_counts: got press=%0d multi=%0d want 2 0", np, nm); end
    checks++; if (v1 !== 2'd1) begin errors++; $display("FAIL overlap_first: got %0d want 1", v1); end
    checks++; if (v2 !== 2'd3) begin errors++; $display("FAIL overlap_repress: got %0d want 3", v2); end
  endtask

  task automatic test_gating();
    int n1 = 0, n2 = 0; logic [1:0] v = 2'd3;
    for (int i = 0; i < 60; i++) begin
      accept_en = (i >= 8);
      btn = (i < 18) ? 4'b0001 : (i >= 33 && i < 48) ? 4'b0001 : 4'b0000;
      tick();
      checks++;
      if ({press_valid, press_val, multi_err, btn_level} !== {m_valid, m_val, m_multi, m_level}) begin
        errors++; $display("FAIL gating_model c%0d: got %b want %b", i, {press_valid, press_val, multi_err, btn_level}, {m_valid, m_val, m_multi, m_level});
      end
      if (press_valid) begin if (i < 33) n1++; else begin n2++; v = press_val; end end
    end
    checks++; if (n1 != 0)    begin errors++; $display("FAIL gating_swallow: got %0d want 0", n1); end
    checks++; if (n2 != 1)    begin errors++; $display("FAIL gating_repress: got %0d want 1", n2); end
    checks++; if (v !== 2'd0) begin errors++; $display("FAIL gating_val: got %0d want 0", v); end
  endtask

  task automatic test_mid_reset();
    int w = 0, at = -1; logic [1:0] v = 2'd0;
    accept_en = 1'b1; btn = 4'b0010;
    while (btn_level[1] !== 1'b1 && w < 20) begin tick(); w++; end
    checks++; if (btn_level[1] !== 1'b1) begin errors++; $display("FAIL reset_wait: got level=%b want xx1x", btn_level); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({press_valid, press_val, multi_err, btn_level} !== 8'h00) begin
      errors++; $display("FAIL reset_mid: got %b want 00000000", {press_valid, press_val, multi_err, btn_level});
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      checks++;
      if ({press_valid, press_val, multi_err, btn_level} !== {m_valid, m_val, m_multi, m_level}) begin
        errors++; $display("FAIL reset_model c%0d: got %b want %b", i, {press_valid, press_val, multi_err, btn_level}, {m_valid, m_val, m_multi, m_level});
      end
      if (press_valid && at < 0) begin at = i; v = press_val; end
    end
    checks++; if (at != 7)    begin errors++; $display("FAIL reset_latency: got %0d want 7", at); end
    checks++; if (v !== 2'd1) begin errors++; $display("FAIL reset_val: got %0d want 1", v); end
    btn = 4'b0000;
    repeat (15) tick();
  endtask

  task automatic test_random();
    int hold;
    int r;
    logic [3:0] b;
    for (int seg = 0; seg < 60; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 3) b = 4'b0000;
      else if (r < 8) b = 4'b0001 << $urandom_range(0, 3);
      else b = 4'($urandom_range(0, 15));
      btn = b;
      accept_en = ($urandom_range(0, 3) != 0);
      hold = $urandom_range(1, 12);
      for (int i = 0; i < hold; i++) begin
        reset = ($urandom_range(0, 59) == 0);
        tick();
        checks++;
        if ({press_valid, press_val, multi_err, btn_level} !== {m_valid, m_val, m_multi, m_level}) begin
          errors++; $display("FAIL random_model s%0d: got %b want %b", seg, {press_valid, press_val, multi_err, btn_level}, {m_valid, m_val, m_multi, m_level});
        end
        if (press_valid && multi_err) begin
          errors++; $display("FAIL random_exclusive: got both pulses want at most one");
        end
      end
    end
    reset = 1'b0; btn = 4'b0000;
    repeat (15) tick();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_overlap();
    test_gating();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
